arbitro_destino: RTL and testbench
==================================

# arbitro_destino

Egress arbiter that sits downstream of the four class FIFOs (VC0–VC3) filled by the class arbiter. It drains them into one of four destination FIFOs, using round-robin selection among non-empty class FIFOs. It routes each word by its destination field and stalls globally when any destination FIFO reports almost-full. It also keeps a per-destination word counter for debug and verification.

## Interface
Parameters:
- WORD_SIZE, 12, word width; [11:10] class, [9:8] destination, [7:0] data
- CNT_WIDTH, 8, width of each per-destination word counter

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- data_in0..data_in3  input  WORD_SIZE each  head word of class FIFO 0..3; show-ahead, valid whenever the matching fifo_empty bit is 0
- fifo_empty  input  4  empty flags of class FIFOs 0..3
- fifos_almost_full  input  4  almost-full flags of destination FIFOs 0..3
- pop  output  4  one-hot-or-zero read strobe to class FIFOs, registered
- push  output  4  one-hot-or-zero write strobe to destination FIFOs, registered
- data_out_arb  output  WORD_SIZE  word written to the destination FIFO selected by push
- cnt_dest  output  4*CNT_WIDTH  words pushed per destination; slice i is [i*CNT_WIDTH +: CNT_WIDTH]

## Operation
- Reset (reset=1 at a clock edge): pop=0, push=0, data_out_arb=0, cnt_dest=0, RR pointer=0, last-popped tag cleared. Reset takes priority over everything, and a pending pop is discarded without a push.
- Issue condition, evaluated every cycle from current inputs: no bit of fifos_almost_full set, and at least one eligible class FIFO.
- A FIFO is eligible when its empty bit is 0 and it was not popped in the immediately preceding cycle, i.e. pop[i] is currently 0. This covers the registered-empty lag and prevents underflow.
- Grant: the first eligible index scanning ptr, ptr+1, … modulo 4. At the edge: pop[grant]<=1, ptr<=grant+1 (2-bit wrap), and the word data_in[grant] is captured into a stage register.
- If the issue condition fails: pop<=0 and ptr is unchanged.
- Push stage, on the edge after a pop:
  - push[dest]<=1, data_out_arb<=captured word, with dest=word[WORD_SIZE-3:WORD_SIZE-4].
  - cnt_dest[dest] increments, wrapping modulo 2^CNT_WIDTH.
- Otherwise push<=0 and data_out_arb<=0.
- A word already popped is always pushed, even if almost_full asserts meanwhile. Destination almost_full thresholds must therefore leave at least 2 free slots.
- Simultaneous events:
  - A pop and a push for different words occur in the same cycle (pipelined).
  - At most one pop and one push per cycle.

## Timing
- Latency: pop[i] high in cycle N, push[dest] high with data in cycle N+1.
- Throughput is 1 word/cycle when at least two class FIFOs are non-empty. A single non-empty FIFO yields 1 word per 2 cycles (pop, bubble, pop, …).
- almost_full rising in cycle N blocks any new pop at edge N. Pushes continue for at most 1 in-flight word.
- fifo_empty becoming 0 in cycle N allows a pop at edge N, with the push in N+2 relative to data arrival.

## Structure
- Shared package holds:
  - NUM_VC=4 and NUM_DEST=4
  - field positions CLASS_MSB/LSB=11/10 and DEST_MSB/LSB=9/8 (for WORD_SIZE=12)
  - the CNT_WIDTH default
- Natural sub-module: arbitro_rr_sel, a combinational round-robin selector with inputs req[3:0] and ptr[1:0], outputs grant_valid and grant_idx[1:0].
- The top level holds the pop/stage register, push/data register, pointer and counters.

## Test plan
- Reset held 3 cycles with FIFOs non-empty -> pop=0, push=0, data_out_arb=0, cnt_dest=0 throughout; the first pop occurs at the first edge after release, on VC0.
- All 4 FIFOs non-empty, no almost_full -> pop sequence 0001, 0010, 0100, 1000, 0001…; each push follows 1 cycle later, with data matching the head word.
- Only VC2 non-empty, with words 0x8A5 and 0x9C3 -> pop pattern 0100, 0000, 0100. Pushes:
  - push[0] with data 0x8A5
  - one idle cycle
  - push[1] with data 0x9C3
- Continuous traffic, fifos_almost_full[3]=1 asserted mid-stream -> exactly one further push, then pop=0 and push=0 until it deasserts. Resuming grants continue from the saved pointer.
- 256+3 words to destination 2 -> cnt_dest[2] wraps to 3 and the other counters stay 0.
- reset asserted in a cycle where pop=0010 -> the following cycle has push=0000, and no counter increments.

Source files
------------

// File: rtl/arbitro_destino_pkg.sv
// rtl/arbitro_destino_pkg.sv - shared constants and helpers for the egress arbiter
package arbitro_destino_pkg;

  localparam int NUM_VC        = 4;
  localparam int NUM_DEST      = 4;
  localparam int WORD_SIZE_DEF = 12;
  localparam int CNT_WIDTH_DEF = 8;

  // Field positions for the default 12-bit word
  localparam int CLASS_MSB = 11;
  localparam int CLASS_LSB = 10;
  localparam int DEST_MSB  = 9;
  localparam int DEST_LSB  = 8;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/arbitro_rr_sel.sv
// rtl/arbitro_rr_sel.sv - combinational round-robin selector, scans ptr, ptr+1, ... modulo 4
module arbitro_rr_sel
  import arbitro_destino_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       grant_valid,
  output logic [1:0] grant_idx
);

  logic [1:0] idx;

  // Scan from farthest to nearest so the first requester after ptr wins last
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr;
    idx         = ptr;
    for (int k = NUM_VC - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/arbitro_destino.sv
// rtl/arbitro_destino.sv - drains four class FIFOs round-robin into four destination FIFOs
module arbitro_destino
  import arbitro_destino_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WORD_SIZE-1:0]          data_in0,
  input  logic [WORD_SIZE-1:0]          data_in1,
  input  logic [WORD_SIZE-1:0]          data_in2,
  input  logic [WORD_SIZE-1:0]          data_in3,
  input  logic [3:0]                    fifo_empty,
  input  logic [3:0]                    fifos_almost_full,
  output logic [3:0]                    pop,
  output logic [3:0]                    push,
  output logic [WORD_SIZE-1:0]          data_out_arb,
  output logic [NUM_DEST*CNT_WIDTH-1:0] cnt_dest
);

  logic [WORD_SIZE-1:0] din [NUM_VC];
  logic [3:0]           eligible;
  logic                 grant_valid;
  logic [1:0]           grant_idx;
  logic                 issue;
  logic [1:0]           dest;

  logic [3:0]           pop_q, pop_d;
  logic [3:0]           push_q, push_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [WORD_SIZE-1:0] stage_q, stage_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_DEST];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_DEST];

  assign din[0] = data_in0;
  assign din[1] = data_in1;
  assign din[2] = data_in2;
  assign din[3] = data_in3;

  // A FIFO popped this cycle still shows its old head; skip it to avoid underflow
  assign eligible = ~fifo_empty & ~pop_q;

  arbitro_rr_sel u_rr_sel (
    .req         (eligible),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign issue = grant_valid && !(|fifos_almost_full);
  assign dest  = stage_q[WORD_SIZE-3:WORD_SIZE-4];

  always_comb begin
    pop_d   = '0;
    ptr_d   = ptr_q;
    stage_d = stage_q;
    if (issue) begin
      pop_d   = onehot4(grant_idx);
      ptr_d   = grant_idx + 2'd1;
      stage_d = din[grant_idx];
    end
  end

  // An issued word is always pushed, regardless of almost-full in the meantime
  always_comb begin
    push_d = '0;
    data_d = '0;
    cnt_d  = cnt_q;
    if (|pop_q) begin
      push_d      = onehot4(dest);
      data_d      = stage_q;
      cnt_d[dest] = cnt_q[dest] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_q   <= '0;
      push_q  <= '0;
      ptr_q   <= '0;
      stage_q <= '0;
      data_q  <= '0;
      for (int i = 0; i < NUM_DEST; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      pop_q   <= pop_d;
      push_q  <= push_d;
      ptr_q   <= ptr_d;
      stage_q <= stage_d;
      data_q  <= data_d;
      for (int i = 0; i < NUM_DEST; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign pop          = pop_q;
  assign push         = push_q;
  assign data_out_arb = data_q;

  for (genvar i = 0; i < NUM_DEST; i++) begin : g_cnt
    assign cnt_dest[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end

endmodule

// File: tb/tb_arbitro_destino.sv
// tb/tb_arbitro_destino.sv - randomized bench for arbitro_destino against a queue-based model
module tb_arbitro_destino;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] data_in0, data_in1, data_in2, data_in3;
  logic [3:0]  fifo_empty;
  logic [3:0]  fifos_almost_full;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [11:0] data_out_arb;
  logic [31:0] cnt_dest;

  always #5 clk = ~clk;

  arbitro_destino dut (
    .clk               (clk),
    .reset             (reset),
    .data_in0          (data_in0),
    .data_in1          (data_in1),
    .data_in2          (data_in2),
    .data_in3          (data_in3),
    .fifo_empty        (fifo_empty),
    .fifos_almost_full (fifos_almost_full),
    .pop               (pop),
    .push              (push),
    .data_out_arb      (data_out_arb),
    .cnt_dest          (cnt_dest)
  );

  int total = 0;
  int bad   = 0;

  // Class FIFO contents as seen by the arbiter, head at index 0
  logic [11:0] vc_q [4][$];

  int          m_ptr;
  logic        m_pend_v;
  logic [11:0] m_pend_w;
  logic [7:0]  m_cnt [4];
  logic [3:0]  cur_pop;
  logic [3:0]  exp_pop, exp_push;
  logic [11:0] exp_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [11:0] head(input int v);
    return (vc_q[v].size() > 0) ? vc_q[v][0] : 12'h000;
  endfunction

  function automatic logic [11:0] rand_word(input int v, input int d);
    logic [11:0] w;
    w        = 12'($urandom);
    w[11:10] = 2'(v);
    if (d >= 0) w[9:8] = 2'(d);
    return w;
  endfunction

  task automatic fill_all();
    for (int v = 0; v < 4; v++)
      while (vc_q[v].size() < 3) vc_q[v].push_back(rand_word(v, -1));
  endtask

  task automatic clear_all();
    for (int v = 0; v < 4; v++) vc_q[v].delete();
  endtask

  task automatic step(input logic [3:0] af, input logic rst);
    int          g;
    logic [31:0] exp_cnt;
    fifos_almost_full = af;
    reset             = rst;
    for (int v = 0; v < 4; v++) fifo_empty[v] = (vc_q[v].size() == 0);
    data_in0 = head(0);
    data_in1 = head(1);
    data_in2 = head(2);
    data_in3 = head(3);
    exp_push = 4'b0000;
    exp_data = 12'h000;
    exp_pop  = 4'b0000;
    if (rst) begin
      m_ptr    = 0;
      m_pend_v = 1'b0;
      m_pend_w = 12'h000;
      for (int d = 0; d < 4; d++) m_cnt[d] = 8'd0;
    end else begin
      if (m_pend_v) begin
        exp_push = 4'b0001 << m_pend_w[9:8];
        exp_data = m_pend_w;
        m_cnt[m_pend_w[9:8]] = m_cnt[m_pend_w[9:8]] + 8'd1;
      end
      g = -1;
      if (af == 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (m_ptr + k) % 4;
          if (g < 0 && vc_q[idx].size() > 0 && !cur_pop[idx]) g = idx;
        end
      end
      m_pend_v = (g >= 0);
      if (g >= 0) begin
        exp_pop  = 4'b0001 << g;
        m_pend_w = head(g);
        m_ptr    = (g + 1) % 4;
      end
    end
    exp_cnt = {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
    @(posedge clk);
    #1;
    check("pop", {28'd0, pop}, {28'd0, exp_pop});
    check("push", {28'd0, push}, {28'd0, exp_push});
    check("data_out", {20'd0, data_out_arb}, {20'd0, exp_data});
    check("cnt_dest", cnt_dest, exp_cnt);
    // The FIFO acts on the strobe that was visible during the cycle just ended
    for (int v = 0; v < 4; v++)
      if (cur_pop[v] && vc_q[v].size() > 0) void'(vc_q[v].pop_front());
    cur_pop = exp_pop;
  endtask

  initial begin
    reset             = 1'b1;
    fifos_almost_full = 4'b0000;
    fifo_empty        = 4'b1111;
    data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
    cur_pop  = 4'b0000;
    m_ptr    = 0;
    m_pend_v = 1'b0;
    m_pend_w = '0;
    for (int d = 0; d < 4; d++) m_cnt[d] = 8'd0;

    // Reset held with non-empty FIFOs, then first grant lands on VC0
    fill_all();
    repeat (3) step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    check("first_pop_vc0", {28'd0, pop}, 32'h1);

    // All four busy: strict rotation at full rate
    repeat (20) begin
      fill_all();
      step(4'b0000, 1'b0);
    end

    // Single busy FIFO gives one word per two cycles
    step(4'b0000, 1'b1);
    clear_all();
    step(4'b0000, 1'b1);
    vc_q[2].push_back(12'h8A5);
    vc_q[2].push_back(12'h9C3);
    step(4'b0000, 1'b0);
    check("vc2_pop_a", {28'd0, pop}, 32'h4);
    step(4'b0000, 1'b0);
    check("vc2_push0", {28'd0, push}, 32'h1);
    check("vc2_data0", {20'd0, data_out_arb}, 32'h8A5);
    step(4'b0000, 1'b0);
    check("vc2_pop_b", {28'd0, pop}, 32'h4);
    step(4'b0000, 1'b0);
    check("vc2_push1", {28'd0, push}, 32'h2);
    check("vc2_data1", {20'd0, data_out_arb}, 32'h9C3);
    repeat (2) step(4'b0000, 1'b0);

    // Almost-full mid-stream: one in-flight push, then stall, then resume
    repeat (6) begin
      fill_all();
      step(4'b0000, 1'b0);
    end
    repeat (5) begin
      fill_all();
      step(4'b1000, 1'b0);
    end
    check("af_stalled_push", {28'd0, push}, 32'h0);
    repeat (6) begin
      fill_all();
      step(4'b0000, 1'b0);
    end

    // Reset while a pop is outstanding discards that word
    begin
      int n;
      n = 0;
      while (cur_pop != 4'b0010 && n < 20) begin
        fill_all();
        step(4'b0000, 1'b0);
        n++;
      end
      check("reached_pop_vc1", {28'd0, pop}, 32'h2);
      step(4'b0000, 1'b1);
      check("rst_no_push", {28'd0, push}, 32'h0);
      check("rst_cnt_zero", cnt_dest, 32'h0);
    end

    // 259 words to destination 2: counter wraps to 3
    clear_all();
    step(4'b0000, 1'b1);
    for (int i = 0; i < 259; i++) vc_q[i % 4].push_back(rand_word(i % 4, 2));
    begin
      int n;
      n = 0;
      while ((vc_q[0].size() + vc_q[1].size() + vc_q[2].size() + vc_q[3].size() > 0
              || m_pend_v || cur_pop != 4'b0000) && n < 400) begin
        step(4'b0000, 1'b0);
        n++;
      end
      check("drain_in_budget", (n < 400) ? 32'd1 : 32'd0, 32'd1);
    end
    step(4'b0000, 1'b0);
    check("wrap_dest2", {24'd0, cnt_dest[23:16]}, 32'd3);
    check("wrap_others", {8'd0, cnt_dest[31:24], cnt_dest[15:0]}, 32'd0);

    // Random traffic, sporadic almost-full and reset
    repeat (300) begin
      logic [3:0] af;
      for (int v = 0; v < 4; v++)
        if ($urandom_range(0, 2) == 0 && vc_q[v].size() < 6) vc_q[v].push_back(rand_word(v, -1));
      af = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      step(af, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
